// File: rtl/select_line_encoder.sv
// Recovers the binary code from a bank of active-low one-hot select lines, with
// synchronisation, debounce, multi-line fault detection and a valid/ready output.
module select_line_encoder #(
  parameter int N_LINES         = 4,
  parameter int CODE_W          = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [N_LINES-1:0] sel_n,
  output logic [CODE_W-1:0]  code_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err,
  output logic               overrun,
  output logic [1:0]         dbg_state
);

  // Handshake: a code transfers on every enabled edge where out_valid & out_ready.
  // out_valid stays high until that transfer; a new accept may overwrite (overrun).

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_ONE   = 2'd1;
  localparam logic [1:0] K_MULTI = 2'd2;

  localparam logic [CODE_W:0]  ONE_LOW  = (CODE_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

  logic [N_LINES-1:0] s1_q, s2_q;
  logic [1:0]         cand_kind_q, cand_kind_d;
  logic [CODE_W-1:0]  cand_idx_q, cand_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic [CODE_W:0]    low_cnt;
  logic [CODE_W-1:0]  low_idx;
  logic [1:0]         cls_kind;
  logic [CODE_W-1:0]  cls_idx;
  logic               changed, stable, accept;

  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (!s2_q[i]) begin
        low_cnt = low_cnt + ONE_LOW;
        low_idx = CODE_W'(i);
      end
    end
    if (low_cnt == '0)          cls_kind = K_NONE;
    else if (low_cnt == ONE_LOW) cls_kind = K_ONE;
    else                         cls_kind = K_MULTI;
    // Index is only meaningful for ONE; forcing 0 otherwise keeps the compare exact.
    cls_idx = (cls_kind == K_ONE) ? low_idx : '0;
  end

  always_comb begin
    changed     = (cls_kind != cand_kind_q) || (cls_idx != cand_idx_q);
    stable      = !changed && (cnt_q == CNT_LAST);
    cand_kind_d = cls_kind;
    cand_idx_d  = cls_idx;
    if (changed)               cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (changed && cls_kind != K_NONE) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (stable) begin
          case (cand_kind_q)
            K_ONE: begin
              state_d = ST_HOLD;
              accept  = 1'b1;
            end
            K_MULTI: state_d = ST_FAULT;
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_HOLD:  if (changed) state_d = ST_SETTLE;
      ST_FAULT: if (changed) state_d = ST_SETTLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (accept) begin
      code_d  = cand_idx_q;
      valid_d = 1'b1;
      if (valid_q && !out_ready) overrun_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // The synchroniser keeps sampling while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= sel_n;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_kind_q <= K_NONE;
      cand_idx_q  <= '0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      code_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (ena) begin
      cand_kind_q <= cand_kind_d;
      cand_idx_q  <= cand_idx_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign code_out  = code_q;
  assign out_valid = valid_q;
  assign err       = (state_q == ST_FAULT);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_select_line_encoder.sv
// Bench for select_line_encoder: directed scenarios plus randomized line patterns,
// checked against a run-length reference model and a handshake scoreboard.
module tb_select_line_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [3:0] sel_n = 4'hF;
  logic       out_ready = 1'b0;
  logic [1:0] code_out;
  logic       out_valid, err, overrun;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [1:0] exp_q[$];

  select_line_encoder #(.N_LINES(4), .CODE_W(2), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sel_n(sel_n),
    .code_out(code_out), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .overrun(overrun), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: -1 = no line low, 0..3 = that single line low, 4 = several low.
  function automatic int classify(input logic [3:0] v);
    int zeros;
    zeros = 4 - $countones(v);
    if (zeros == 0) return -1;
    if (zeros > 1) return 4;
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return -1;
  endfunction

  logic [3:0] m_h0 = 4'hF, m_h1 = 4'hF;
  int  m_prev = -1, m_run = 1, m_mode = 0;
  bit  m_valid = 0, m_over = 0;
  int  m_code = 0;

  always @(posedge clk) begin
    int c;
    bit chg, stab, acc;
    if (rst) begin
      m_h0 = 4'hF; m_h1 = 4'hF;
      m_prev = -1; m_run = 1; m_mode = 0;
      m_valid = 0; m_over = 0; m_code = 0;
      exp_q.delete();
    end else begin
      if (ena) begin
        c    = classify(m_h1);
        chg  = (c != m_prev);
        if (chg) m_run = 1;
        else if (m_run < D + 2) m_run++;
        stab = (m_run == D + 1);
        m_prev = c;
        acc = 0;
        case (m_mode)
          0: if (c != -1) m_mode = 1;
          1: if (stab) begin
               if (c == -1) m_mode = 0;
               else if (c == 4) m_mode = 3;
               else begin m_mode = 2; acc = 1; end
             end
          default: if (chg) m_mode = 1;
        endcase
        if (acc) begin
          if (m_valid && !out_ready) begin
            m_over = 1;
            if (exp_q.size() > 0) void'(exp_q.pop_back());
          end
          exp_q.push_back(2'(c));
          m_valid = 1; m_code = c;
        end else if (m_valid && out_ready) begin
          m_valid = 0;
        end
      end
      m_h1 = m_h0;
      m_h0 = sel_n;
    end
  end

  // Monitor: each transferred code is popped from the expected queue.
  always @(posedge clk) begin
    bit fire;
    logic [1:0] got;
    fire = out_valid && out_ready && ena && !rst;
    got  = code_out;
    #1;
    if (fire) begin
      if (exp_q.size() == 0) chk("handshake_unexpected", 1, 0);
      else chk("handshake_code", got, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_valid", out_valid, m_valid);
      chk("cyc_code", code_out, m_code);
      chk("cyc_err", err, m_mode == 3);
      chk("cyc_overrun", overrun, m_over);
      chk("cyc_state", dbg_state, m_mode);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic consume();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] v;
    int len;
    tick(); rst = 1'b0; chk_on = 1'b1;
    chk("reset_valid", out_valid, 0);
    chk("reset_code", code_out, 0);
    chk("reset_err_ovr", {err, overrun}, 0);

    // 1: single code accepted after debounce, then consumed
    sel_n = 4'b1110;
    tick(6); chk("t1_not_yet", out_valid, 0);
    tick();  chk("t1_valid", out_valid, 1); chk("t1_code", code_out, 0);
    consume(); chk("t1_consumed", out_valid, 0);

    // 2: short glitch is never accepted
    sel_n = 4'hF; tick(8);
    sel_n = 4'b1011; tick(3);
    sel_n = 4'hF;
    for (int i = 0; i < 12; i++) begin tick(); chk("t2_err", err, 0); end
    chk("t2_valid", out_valid, 0); chk("t2_state", dbg_state, 0);

    // 3: multi-line fault, then recovery to code 3
    sel_n = 4'b0101; tick(7);
    chk("t3_err", err, 1); chk("t3_novalid", out_valid, 0);
    sel_n = 4'b0111; tick(7);
    chk("t3_err_clr", err, 0); chk("t3_code", code_out, 3); chk("t3_valid", out_valid, 1);
    consume();

    // 4: overrun when second code arrives unconsumed
    sel_n = 4'b1101; tick(7); chk("t4_code1", code_out, 1);
    sel_n = 4'hF; tick(8);
    sel_n = 4'b1011; tick(7);
    chk("t4_code2", code_out, 2); chk("t4_valid", out_valid, 1); chk("t4_overrun", overrun, 1);
    consume(); tick(10);
    chk("t4_sticky", overrun, 1); chk("t4_drained", out_valid, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_rst_overrun", overrun, 0);

    // 5: consume and accept on the same edge is a clean replace
    sel_n = 4'b1101; tick(7); chk("t5_code1", code_out, 1);
    sel_n = 4'b0111; tick(6); chk("t5_pending", code_out, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t5_valid", out_valid, 1); chk("t5_code3", code_out, 3); chk("t5_no_ovr", overrun, 0);
    consume();

    // 6: ena freeze mid-SETTLE, resume, then reset in HOLD
    sel_n = 4'b1110; tick(4); chk("t6_settle", dbg_state, 1);
    ena = 1'b0; tick(10);
    chk("t6_frozen_valid", out_valid, 0); chk("t6_frozen_state", dbg_state, 1);
    ena = 1'b1; tick(2); chk("t6_not_yet", out_valid, 0);
    tick(); chk("t6_valid", out_valid, 1); chk("t6_code", code_out, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_valid", out_valid, 0); chk("t6_rst_state", dbg_state, 0);

    // Randomized segments
    for (int s = 0; s < 90; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: v = 4'hF;
        8, 9: begin
          v = 4'($urandom_range(0, 15));
          while ($countones(v) > 2) v = 4'($urandom_range(0, 15));
        end
        default: v = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      sel_n = v;
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        ena       = ($urandom_range(0, 15) != 0);
        rst       = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    rst = 1'b0; ena = 1'b1; out_ready = 1'b0;
    tick(2);
    chk("final_queue_depth", exp_q.size(), out_valid);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
